pllcfg_cmd_ctrl: RTL and testbench
==================================

Name: pllcfg_cmd_ctrl

Overview:
Fabric-side command sequencer that sits directly upstream of the soft-CPU's PLL-configuration command/status port. It takes single PLL requests (reconfigure, reset, phase search, abort-handshake) from the host register map and drives the 4-bit one-hot command bus into the CPU. It tracks the CPU's busy/done/error status with acknowledge and completion timeouts, then returns a single coded response to the requester.

Parameters:
ACK_TIMEOUT, 1000, clocks allowed for CPU to raise busy after command asserted (also bounds wait for stale busy to clear)
DONE_TIMEOUT, 16000000, clocks allowed from busy seen to done/error
CNT_W, 24, timeout counter width; both timeouts must be < 2**CNT_W

Ports:
clk  in  1  system clock, same domain as CPU
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  request strobe/level
req_ready  out  1  high only in IDLE; transfer = req_valid & req_ready
req_type  in  2  0 reconfig, 1 pll reset, 2 phase search, 3 aux command
abort  in  1  level; cancels any in-flight request
pllcfg_cmd  out  4  one-hot command to CPU, bit = req_type
pllcfg_stat  in  10  [0] busy, [1] done, [2] error, [9:3] CPU detail code
rsp_valid  out  1  response available, held until rsp_ready
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
rsp_code  out  3  0 ok, 1 CPU error, 2 ack timeout, 3 done timeout, 4 aborted
rsp_info  out  7  pllcfg_stat[9:3] captured at completion (0 for timeouts/abort)
busy  out  1  high in any state except IDLE

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. Async reset (reset_n low) forces state IDLE, counter 0, and all outputs to 0 except req_ready=1. Reset mid-operation drops pllcfg_cmd in the same event and produces no response.
- States: IDLE, WAIT_CLR, ISSUE, WAIT_DONE, RESP.
- IDLE:
  - req_ready=1.
  - On transfer: latch req_type, clear counter.
  - Next state is WAIT_CLR if stat[0]=1, else ISSUE.
- WAIT_CLR:
  - Stale busy from a prior op; pllcfg_cmd=0.
  - stat[0]=0 -> ISSUE, counter cleared.
  - Counter reaching ACK_TIMEOUT-1 -> RESP with code 2.
- ISSUE:
  - pllcfg_cmd = 1<<type, registered; first asserted the cycle after entry.
  - stat[0]=1 -> WAIT_DONE, counter cleared; pllcfg_cmd drops to 0 on that same transition edge.
  - Timeout after ACK_TIMEOUT cycles -> RESP with code 2, cmd dropped.
- WAIT_DONE:
  - pllcfg_cmd=0.
  - Completion condition: stat[0]=0 and (stat[1] or stat[2]).
  - stat[2]=1 gives code 1; this wins over done when both are set.
  - Otherwise code 0.
  - On completion, rsp_info captured from stat[9:3].
  - Busy falling with neither done nor error: keep waiting (counter continues).
  - Timeout after DONE_TIMEOUT cycles -> code 3.
- RESP:
  - rsp_valid=1; rsp_code and rsp_info stable.
  - On rsp_ready -> IDLE; rsp_valid=0 next cycle.
  - Back-to-back: req_ready is not asserted until the cycle after the handshake.
- abort:
  - Sampled in WAIT_CLR, ISSUE, WAIT_DONE.
  - Forces RESP with code 4 next cycle and drops cmd.
  - Ignored in IDLE and RESP.
  - Priority: reset > abort > completion > timeout.
- Counter:
  - Increments once per cycle in timed states; saturates.
  - Cleared on every state change.
- pllcfg_cmd is never multi-hot. It is never asserted outside ISSUE.
- Request latency: transfer at edge N, cmd high at N+1 (ISSUE path).

Test Plan:
1. Reset with req_valid=1 held -> after release, req_ready=1, cmd=0. Type 0 accepted; stat busy at +3 cycles, then busy=0/done=1/detail=0x15 -> cmd=0001 for exactly 3 cycles, rsp_code=0, rsp_info=0x15.
2. Type 2 request, CPU never raises busy, ACK_TIMEOUT=8 -> cmd=0100 for 8 cycles, then rsp_code=2, rsp_info=0.
3. Busy=1 already at accept, clears after 5 cycles -> cmd stays 0 during WAIT_CLR, cmd=0100 thereafter. Done with error=1 and done=1 together -> rsp_code=1.
4. Type 1, busy seen, no completion, DONE_TIMEOUT=20 -> rsp_code=3 exactly 20 cycles after the busy edge. Hold rsp_ready=0 for 10 cycles -> rsp_valid and code stable; req_ready=0 throughout.
5. abort pulse 2 cycles into WAIT_DONE -> cmd=0, rsp_code=4 next cycle. New request afterward completes normally with code 0.
6. Assert reset_n=0 mid-ISSUE, asynchronously between edges -> cmd=0 and rsp_valid=0 immediately. After release the block is in IDLE with no spurious response.

Source files
------------

// File: rtl/pllcfg_cmd_ctrl.sv
// PLL-configuration command sequencer: accepts one host request, drives the one-hot
// command into the soft-CPU, tracks busy/done/error with timeouts and returns a coded response.
module pllcfg_cmd_ctrl #(
  parameter int ACK_TIMEOUT  = 1000,
  parameter int DONE_TIMEOUT = 16000000,
  parameter int CNT_W        = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_type,
  input  logic        abort,
  output logic [3:0]  pllcfg_cmd,
  input  logic [9:0]  pllcfg_stat,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [2:0]  rsp_code,
  output logic [6:0]  rsp_info,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  // Handshakes: a request transfers when req_valid & req_ready at a rising edge; a
  // response is consumed when rsp_valid & rsp_ready. Each valid holds until accepted.

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_CLR  = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RESP      = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'(DONE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  localparam logic [2:0] CODE_OK    = 3'd0;
  localparam logic [2:0] CODE_ERR   = 3'd1;
  localparam logic [2:0] CODE_ACKTO = 3'd2;
  localparam logic [2:0] CODE_DONTO = 3'd3;
  localparam logic [2:0] CODE_ABORT = 3'd4;

  state_t           state, state_d;
  logic [1:0]       type_q, type_d;
  logic [2:0]       code_q, code_d;
  logic [6:0]       info_q, info_d;
  logic [3:0]       cmd_q, cmd_d;
  logic [CNT_W-1:0] cnt;
  logic             timed;

  logic stat_busy, stat_done, stat_err;
  assign stat_busy = pllcfg_stat[0];
  assign stat_done = pllcfg_stat[1];
  assign stat_err  = pllcfg_stat[2];

  always_comb begin
    state_d = state;
    type_d  = type_q;
    code_d  = code_q;
    info_d  = info_q;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          type_d  = req_type;
          state_d = stat_busy ? S_WAIT_CLR : S_ISSUE;
        end
      end
      S_WAIT_CLR: begin
        if (abort) begin
          state_d = S_RESP; code_d = CODE_ABORT; info_d = '0;
        end else if (!stat_busy) begin
          state_d = S_ISSUE;
        end else if (cnt >= ACK_LAST) begin
          state_d = S_RESP; code_d = CODE_ACKTO; info_d = '0;
        end
      end
      S_ISSUE: begin
        if (abort) begin
          state_d = S_RESP; code_d = CODE_ABORT; info_d = '0;
        end else if (stat_busy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt >= ACK_LAST) begin
          state_d = S_RESP; code_d = CODE_ACKTO; info_d = '0;
        end
      end
      S_WAIT_DONE: begin
        // Busy dropping without done/error is not completion; keep waiting.
        if (abort) begin
          state_d = S_RESP; code_d = CODE_ABORT; info_d = '0;
        end else if (!stat_busy && (stat_done || stat_err)) begin
          state_d = S_RESP;
          code_d  = stat_err ? CODE_ERR : CODE_OK;
          info_d  = pllcfg_stat[9:3];
        end else if (cnt >= DONE_LAST) begin
          state_d = S_RESP; code_d = CODE_DONTO; info_d = '0;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Command register follows the next state so it rises on ISSUE entry and drops on exit.
  always_comb begin
    cmd_d = '0;
    if (state_d == S_ISSUE) cmd_d = 4'b0001 << type_d;
  end

  assign timed = (state == S_WAIT_CLR) || (state == S_ISSUE) || (state == S_WAIT_DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      type_q <= '0;
      code_q <= '0;
      info_q <= '0;
      cmd_q  <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_d;
      type_q <= type_d;
      code_q <= code_d;
      info_q <= info_d;
      cmd_q  <= cmd_d;
      if (state_d != state) cnt <= '0;
      else if (timed && (cnt != CNT_MAX)) cnt <= cnt + CNT_W'(1);
    end
  end

  assign req_ready  = (state == S_IDLE);
  assign rsp_valid  = (state == S_RESP);
  assign busy       = (state != S_IDLE);
  assign pllcfg_cmd = cmd_q;
  assign rsp_code   = code_q;
  assign rsp_info   = info_q;
  assign dbg_state  = state;

endmodule

// File: tb/tb_pllcfg_cmd_ctrl.sv
// Directed bench for pllcfg_cmd_ctrl with short timeouts (ACK 8, DONE 20) and
// hand-computed expectations checked by immediate assertions.
module tb_pllcfg_cmd_ctrl;

  logic       clk;
  logic       reset_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_type;
  logic       abort;
  logic [3:0] pllcfg_cmd;
  logic [9:0] pllcfg_stat;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [2:0] rsp_code;
  logic [6:0] rsp_info;
  logic       busy;
  logic [2:0] dbg_state;

  int n_pass = 0;
  int n_chk  = 0;
  int n;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_WCLR = 3'd1, ST_ISSUE = 3'd2,
                         ST_WDONE = 3'd3, ST_RESP = 3'd4;

  pllcfg_cmd_ctrl #(.ACK_TIMEOUT(8), .DONE_TIMEOUT(20), .CNT_W(24)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .abort(abort), .pllcfg_cmd(pllcfg_cmd),
    .pllcfg_stat(pllcfg_stat), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_code(rsp_code), .rsp_info(rsp_info), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [9:0] stat(input logic [6:0] det, input logic err,
                                      input logic done, input logic bsy);
    return {det, err, done, bsy};
  endfunction

  initial begin
    reset_n     = 1'b0;
    req_valid   = 1'b1;
    req_type    = 2'd0;
    abort       = 1'b0;
    pllcfg_stat = '0;
    rsp_ready   = 1'b0;

    // 1: reset with req_valid held, then a normal type-0 completion
    tick; tick;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_cmd", 32'(pllcfg_cmd), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    chk("rel_req_ready", 32'(req_ready), 32'd1);
    chk("rel_state", 32'(dbg_state), 32'(ST_IDLE));
    tick;
    req_valid = 1'b0;
    chk("t1_cmd_c0", 32'(pllcfg_cmd), 32'h1);
    chk("t1_req_ready", 32'(req_ready), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    tick;
    chk("t1_cmd_c1", 32'(pllcfg_cmd), 32'h1);
    tick;
    chk("t1_cmd_c2", 32'(pllcfg_cmd), 32'h1);
    pllcfg_stat = stat(7'h00, 1'b0, 1'b0, 1'b1);
    tick;
    chk("t1_cmd_drop", 32'(pllcfg_cmd), 32'h0);
    chk("t1_wait_done", 32'(dbg_state), 32'(ST_WDONE));
    pllcfg_stat = stat(7'h15, 1'b0, 1'b1, 1'b0);
    tick;
    pllcfg_stat = '0;
    chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t1_rsp_code", 32'(rsp_code), 32'd0);
    chk("t1_rsp_info", 32'(rsp_info), 32'h15);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk("t1_rsp_gone", 32'(rsp_valid), 32'd0);
    chk("t1_idle_ready", 32'(req_ready), 32'd1);

    // 2: type 2, CPU never acknowledges -> ack timeout after 8 command cycles
    req_valid = 1'b1;
    req_type  = 2'd2;
    tick;
    req_valid = 1'b0;
    n = 0;
    while (pllcfg_cmd == 4'b0100 && n < 50) begin
      n++;
      tick;
    end
    chk("t2_cmd_cycles", 32'(n), 32'd8);
    chk("t2_cmd_drop", 32'(pllcfg_cmd), 32'h0);
    chk("t2_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t2_rsp_code", 32'(rsp_code), 32'd2);
    chk("t2_rsp_info", 32'(rsp_info), 32'd0);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;

    // 3: stale busy for 5 cycles, then error+done together -> CPU error code
    pllcfg_stat = stat(7'h00, 1'b0, 1'b0, 1'b1);
    req_valid   = 1'b1;
    req_type    = 2'd2;
    tick;
    req_valid = 1'b0;
    chk("t3_wait_clr", 32'(dbg_state), 32'(ST_WCLR));
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (pllcfg_cmd != 4'b0000) n++;
      tick;
    end
    if (pllcfg_cmd != 4'b0000) n++;
    chk("t3_cmd_quiet", 32'(n), 32'd0);
    pllcfg_stat = '0;
    tick;
    chk("t3_cmd_issue", 32'(pllcfg_cmd), 32'h4);
    pllcfg_stat = stat(7'h00, 1'b0, 1'b0, 1'b1);
    tick;
    chk("t3_cmd_drop", 32'(pllcfg_cmd), 32'h0);
    pllcfg_stat = stat(7'h2A, 1'b1, 1'b1, 1'b0);
    tick;
    pllcfg_stat = '0;
    chk("t3_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t3_rsp_code", 32'(rsp_code), 32'd1);
    chk("t3_rsp_info", 32'(rsp_info), 32'h2A);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;

    // 4: type 1, busy seen then falls with no done -> done timeout 20 cycles after busy edge
    req_valid = 1'b1;
    req_type  = 2'd1;
    tick;
    req_valid = 1'b0;
    chk("t4_cmd", 32'(pllcfg_cmd), 32'h2);
    pllcfg_stat = stat(7'h00, 1'b0, 1'b0, 1'b1);
    tick;
    pllcfg_stat = '0;
    n = 0;
    while (!rsp_valid && n < 100) begin
      tick;
      n++;
    end
    chk("t4_timeout_cycles", 32'(n), 32'd20);
    chk("t4_rsp_code", 32'(rsp_code), 32'd3);
    chk("t4_rsp_info", 32'(rsp_info), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("t4_hold_valid", 32'(rsp_valid), 32'd1);
      chk("t4_hold_code", 32'(rsp_code), 32'd3);
      chk("t4_hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;

    // 5: abort two cycles into WAIT_DONE, abort ignored in IDLE, then normal op
    req_valid = 1'b1;
    req_type  = 2'd3;
    tick;
    req_valid = 1'b0;
    chk("t5_cmd", 32'(pllcfg_cmd), 32'h8);
    pllcfg_stat = stat(7'h00, 1'b0, 1'b0, 1'b1);
    tick;
    tick;
    chk("t5_in_wait_done", 32'(dbg_state), 32'(ST_WDONE));
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("t5_abort_cmd", 32'(pllcfg_cmd), 32'h0);
    chk("t5_abort_valid", 32'(rsp_valid), 32'd1);
    chk("t5_abort_code", 32'(rsp_code), 32'd4);
    chk("t5_abort_info", 32'(rsp_info), 32'd0);
    rsp_ready = 1'b1;
    tick;
    rsp_ready   = 1'b0;
    pllcfg_stat = '0;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("t5_idle_abort_valid", 32'(rsp_valid), 32'd0);
    chk("t5_idle_abort_busy", 32'(busy), 32'd0);
    req_valid = 1'b1;
    req_type  = 2'd0;
    tick;
    req_valid = 1'b0;
    chk("t5_new_cmd", 32'(pllcfg_cmd), 32'h1);
    pllcfg_stat = stat(7'h00, 1'b0, 1'b0, 1'b1);
    tick;
    pllcfg_stat = stat(7'h7F, 1'b0, 1'b1, 1'b0);
    tick;
    pllcfg_stat = '0;
    chk("t5_new_code", 32'(rsp_code), 32'd0);
    chk("t5_new_info", 32'(rsp_info), 32'h7F);
    // back-to-back: no req_ready during the response handshake cycle
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_type  = 2'd1;
    chk("t5_b2b_not_ready", 32'(req_ready), 32'd0);
    tick;
    rsp_ready = 1'b0;
    chk("t5_b2b_rsp_gone", 32'(rsp_valid), 32'd0);
    chk("t5_b2b_ready", 32'(req_ready), 32'd1);
    tick;
    req_valid = 1'b0;
    chk("t5_b2b_cmd", 32'(pllcfg_cmd), 32'h2);

    // 6: asynchronous reset mid-ISSUE
    #3;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_cmd", 32'(pllcfg_cmd), 32'h0);
    chk("t6_rst_valid", 32'(rsp_valid), 32'd0);
    chk("t6_rst_ready", 32'(req_ready), 32'd1);
    tick;
    reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (rsp_valid || pllcfg_cmd != 4'b0000 || dbg_state != ST_IDLE) n++;
    end
    chk("t6_post_quiet", 32'(n), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
